// File: rtl/srl_feeder_if.sv
// Bundle between srl_feeder and its neighbours: the upstream sample stream,
// the delay-line drive and the status flags.
interface srl_feeder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    logic                    in_valid;
    logic                    in_ready;
    logic [2*DATA_WIDTH-1:0] in_data;
    logic                    flush;
    logic                    out_ready;
    logic                    srl_ce;
    logic [2*DATA_WIDTH-1:0] srl_din;
    logic                    out_valid;
    logic                    primed;
    logic [LW-1:0]           fifo_level;
    logic                    busy;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  in_ready, srl_ce, srl_din, out_valid, primed, fifo_level, busy
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output in_ready, srl_ce, srl_din, out_valid, primed, fifo_level, busy
    );
endinterface

// File: rtl/srl_feeder.sv
// Feeds the srl delay line from a small FIFO, flags real samples at dout
// and flushes the line with zeros on request.
module srl_feeder #(
    parameter int DATA_WIDTH = 16,
    parameter int REG_NUM    = 32,
    parameter int FIFO_DEPTH = 4
) (
    input logic         clk,
    input logic         rst,
    srl_feeder_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(REG_NUM + 1);
    localparam int SW = CW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_ZERO  = 2'd3;

    logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic [1:0]    state;
    logic [1:0]    state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [CW-1:0] z;
    logic [CW-1:0] z_n;
    logic [SW-1:0] index;
    logic          stream;
    logic          full;
    logic          empty;
    logic          accept;
    logic          avail;
    logic          produce;
    logic          shift;
    logic          pop;
    logic          out_valid;
    logic          primed;
    logic          busy;

    assign stream  = (state == S_RUN) || (state == S_DRAIN);
    assign full    = level == LW'(FIFO_DEPTH);
    assign empty   = level == '0;
    assign accept  = bus.in_valid && bus.in_ready;
    assign avail   = stream ? !empty : (state == S_ZERO);
    // index after this shift; one extra bit keeps cnt + z + 1 from wrapping
    assign index   = SW'(cnt) + SW'(z) + SW'(1);
    assign produce = index >= SW'(REG_NUM);
    assign shift   = avail && (!produce || bus.out_ready);
    assign pop     = shift && stream;

    assign bus.in_ready   = ((state == S_IDLE) || (state == S_RUN)) && !full;
    assign bus.srl_ce     = shift;
    assign bus.srl_din    = stream ? mem[rd_ptr] : '0;
    assign bus.out_valid  = out_valid;
    assign bus.primed     = primed;
    assign bus.busy       = busy;
    assign bus.fifo_level = level;

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= bus.in_data;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        z_n     = z;
        if (pop && cnt != CW'(REG_NUM)) cnt_n = cnt + CW'(1);
        case (state)
            S_IDLE:  if (accept) state_n = S_RUN;
            S_RUN:   if (bus.flush) state_n = S_DRAIN;
            S_DRAIN: if (empty) state_n = S_ZERO;
            S_ZERO: begin
                if (shift) begin
                    if (z == CW'(REG_NUM - 2)) begin
                        state_n = S_IDLE;
                        cnt_n   = '0;
                        z_n     = '0;
                    end else begin
                        z_n = z + CW'(1);
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            cnt       <= '0;
            z         <= '0;
            out_valid <= 1'b0;
            primed    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            z         <= z_n;
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level     <= level + LW'(accept) - LW'(pop);
            out_valid <= shift && produce;
            primed    <= cnt_n == CW'(REG_NUM);
            busy      <= state_n != S_IDLE;
        end
    end
endmodule
